fifo_sync_param: RTL and testbench
==================================

// Module: fifo_sync_param
// PURPOSE
//  Parametrised single-clock FIFO; successor to the fixed 8x32 fifo. Generic width/depth,
//  true pointer wrap-around, occupancy count, programmable almost-full/almost-empty
//  thresholds, sticky overflow/underflow flags and legal simultaneous read+write.
//  Sits between the ui_in/uio_in pins and the consuming logic; status is exported to uio_out.
// PARAMETERS
//  WIDTH     8   data width in bits (>=1)
//  DEPTH     32  entries; power of two, >=2
//  AF_LEVEL  28  almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL  4   almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
//  AW        $clog2(DEPTH), localparam; pointers are AW+1 bits, count is AW+1 bits
// PORTS
//  clk           in   1       clock, all logic on posedge
//  rst_n         in   1       synchronous active-low reset
//  wr_en         in   1       write request
//  wr_data       in   WIDTH   write data, sampled when the write is accepted
//  rd_en         in   1       read request
//  rd_data       out  WIDTH   read data, registered
//  rd_valid      out  1       1-cycle pulse: rd_data holds the word from the accepted read
//  full          out  1       count == DEPTH
//  empty         out  1       count == 0
//  almost_full   out  1       count >= AF_LEVEL
//  almost_empty  out  1       count <= AE_LEVEL
//  overflow      out  1       sticky: write attempted while full and not accepted
//  underflow     out  1       sticky: read attempted while empty
//  clear_flags   in   1       synchronous clear of overflow/underflow
//  count         out  AW+1    current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): wr_ptr=rd_ptr=0, count=0, rd_data=0, rd_valid=0,
//    overflow=underflow=0 -> empty=1, almost_empty=1, full=0, almost_full=0.
//    Storage array is not reset. Reset wins over all other inputs, mid-operation included.
//  - Pointers AW+1 bits, increment mod 2^(AW+1); address = ptr[AW-1:0]. Wrap is seamless.
//  - do_rd = rd_en & ~empty. do_wr = wr_en & (~full | do_rd).
//  - Full + rd_en + wr_en: both accepted, count unchanged. Read returns oldest word; new word
//    is written to the freed slot.
//  - Empty + rd_en + wr_en: write accepted, read rejected (no fall-through), underflow sets.
//  - do_rd: rd_data <= mem[rd_ptr] at the same edge, rd_valid=1 in the following cycle;
//    read latency 1 clk. Without do_rd, rd_valid=0 and rd_data holds its last value.
//  - do_wr: mem[wr_ptr] <= wr_data; the word is readable from the next cycle.
//  - count: +1 on do_wr only, -1 on do_rd only, unchanged on both or neither.
//  - full/empty/almost_* decode combinationally from registered count and update the
//    cycle after the accepting edge.
//  - overflow sets when wr_en & ~do_wr. underflow sets when rd_en & empty. Both hold until
//    clear_flags or reset; set has priority over clear_flags in the same cycle.
//  - Rejected operations do not touch pointers, count, memory or rd_data.
// TESTING
//  1 Reset: rst_n=0 for 2 clks -> count=0, empty=1, almost_empty=1, full=0, flags=0, rd_valid=0.
//  2 Fill/drain: write 0x00..0x1F, then 32 reads -> rd_data 0x00..0x1F in order, each 1 clk
//    after its rd_en. full=1 at count 32; almost_full rises at count 28; empty=1 at end.
//  3 Wrap: 20 writes, 20 reads, 20 writes (0xA0..0xB3), 20 reads -> returns 0xA0..0xB3 in order.
//  4 Full + rd_en + wr_en (0x5A) -> count stays 32, reads oldest word, 0x5A read last;
//    overflow=0. Then wr_en alone while full -> overflow=1, count=32, contents unchanged.
//  5 Empty + rd_en + wr_en (0x33) -> count=1, rd_valid=0, underflow=1. Next read -> 0x33.
//    clear_flags -> underflow=0.
//  6 Reset mid-stream at count=10 -> next cycle count=0, empty=1, rd_valid=0. Next write/read
//    pair returns the new data.

Source files
------------

// File: rtl/fifo_sync_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sync_param_if
//  Purpose  : Bundles the write/read handshake and status signals of
//             fifo_sync_param.
//             master : producer/consumer side (drives requests, sees status)
//             slave  : FIFO side (sees requests, drives data/status)
//  Signals  : wr_en, wr_data, rd_en, clear_flags          (master -> slave)
//             rd_data, rd_valid, full, empty, almost_full,
//             almost_empty, overflow, underflow, count     (slave -> master)
//  Revision : 1.0  initial parametrised release
// ============================================================================
interface fifo_sync_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic             clear_flags;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;
    logic [AW:0]      count;

    modport master (
        output wr_en, wr_data, rd_en, clear_flags,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               overflow, underflow, count
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clear_flags,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               overflow, underflow, count
    );
endinterface
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sync_param
//  Purpose  : Parametrised single-clock FIFO with occupancy count,
//             programmable almost-full/almost-empty thresholds, sticky
//             overflow/underflow flags and simultaneous read+write.
//  Ports    : clk    - clock, all logic on rising edge
//             rst_n  - synchronous active-low reset
//             bus    - fifo_sync_param_if.slave (requests in, data/status out)
//  Params   : WIDTH, DEPTH (power of two, >=2), AF_LEVEL (1..DEPTH),
//             AE_LEVEL (0..DEPTH-1)
//  Revision : 1.0  initial parametrised release
// ============================================================================
module fifo_sync_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = 28,
    parameter int AE_LEVEL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_sync_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0] c_DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_AF_CNT    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] c_AE_CNT    = (AW+1)'(AE_LEVEL);

    // Storage is deliberately left without reset.
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic w_empty;
    logic w_full;
    logic w_do_rd;
    logic w_do_wr;

    // Status decodes straight from the registered count.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH_CNT);

    // A read on a full FIFO frees a slot in the same cycle, so a concurrent
    // write is accepted. A read on an empty FIFO is never accepted, so there
    // is no write-to-read fall-through.
    assign w_do_rd = bus.rd_en & ~w_empty;
    assign w_do_wr = bus.wr_en & (~w_full | w_do_rd);

    // Storage write; reset suppresses it so a reset cycle leaves memory alone.
    always_ff @(posedge clk) begin
        if (rst_n && w_do_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bus.wr_data;
        end
    end

    // Pointers carry one extra bit and wrap modulo 2^(AW+1); only the low AW
    // bits address the array.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: simultaneous accept leaves it unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_do_wr && !w_do_rd) begin
            r_count <= r_count + 1'b1;
        end else if (w_do_rd && !w_do_wr) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Registered read port; rd_data holds its last value when no read occurs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_do_rd;
            if (w_do_rd) begin
                r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
            end
        end
    end

    // Sticky error flags; a new error event overrides clear_flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (bus.wr_en & ~w_do_wr) | (r_overflow  & ~bus.clear_flags);
            r_underflow <= (bus.rd_en & w_empty)  | (r_underflow & ~bus.clear_flags);
        end
    end

    assign bus.rd_data      = r_rd_data;
    assign bus.rd_valid     = r_rd_valid;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= c_AF_CNT);
    assign bus.almost_empty = (r_count <= c_AE_CNT);
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
    assign bus.count        = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_sync_param
//  Purpose  : Self-checking bench for fifo_sync_param: directed vector table,
//             hand-written corner sequences and randomised traffic, all
//             compared against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_sync_param;
    localparam int WIDTH    = 8;
    localparam int DEPTH    = 32;
    localparam int AF_LEVEL = 28;
    localparam int AE_LEVEL = 4;

    logic clk = 1'b0;
    logic rst_n;

    fifo_sync_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fifo_sync_param #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AF_LEVEL),
        .AE_LEVEL(AE_LEVEL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: contents as a queue, plus the visible registered state.
    logic [7:0] q[$];
    logic [7:0] m_rd_data;
    logic       m_rv;
    logic       m_ovf;
    logic       m_unf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_model();
        check("count",        32'(bus.count),        32'(q.size()));
        check("empty",        32'(bus.empty),        32'(q.size() == 0));
        check("full",         32'(bus.full),         32'(q.size() == DEPTH));
        check("almost_full",  32'(bus.almost_full),  32'(q.size() >= AF_LEVEL));
        check("almost_empty", 32'(bus.almost_empty), 32'(q.size() <= AE_LEVEL));
        check("rd_valid",     32'(bus.rd_valid),     32'(m_rv));
        check("rd_data",      32'(bus.rd_data),      32'(m_rd_data));
        check("overflow",     32'(bus.overflow),     32'(m_ovf));
        check("underflow",    32'(bus.underflow),    32'(m_unf));
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic apply(input logic rn, input logic we, input logic re,
                         input logic clr, input logic [7:0] d);
        bit was_empty, was_full, do_rd, do_wr;
        rst_n           = rn;
        bus.wr_en       = we;
        bus.rd_en       = re;
        bus.clear_flags = clr;
        bus.wr_data     = d;
        @(posedge clk);
        was_empty = (q.size() == 0);
        was_full  = (q.size() == DEPTH);
        if (!rn) begin
            q.delete();
            m_rd_data = '0;
            m_rv      = 1'b0;
            m_ovf     = 1'b0;
            m_unf     = 1'b0;
        end else begin
            do_rd = re && !was_empty;
            do_wr = we && (!was_full || do_rd);
            m_rv  = do_rd;
            if (do_rd) m_rd_data = q.pop_front();
            if (do_wr) q.push_back(d);
            m_ovf = (we && !do_wr) || (m_ovf && !clr);
            m_unf = (re && was_empty) || (m_unf && !clr);
        end
        #1;
        check_model();
    endtask

    task automatic idle();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    typedef struct {
        logic       rn, we, re, clr;
        logic [7:0] d;
        logic [5:0] cnt;
        logic       emp, ful, rv;
        logic [7:0] rdat;
        logic       ovf, unf;
    } vec_t;

    vec_t vecs[12];

    initial begin
        rst_n           = 1'b0;
        bus.wr_en       = 1'b0;
        bus.rd_en       = 1'b0;
        bus.clear_flags = 1'b0;
        bus.wr_data     = '0;
        m_rd_data = '0; m_rv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

        //          rn  we  re  clr  d      cnt emp ful rv rdat   ovf unf
        vecs[0]  = '{0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0};
        vecs[1]  = '{0, 1, 1, 0, 8'hEE, 0, 1, 0, 0, 8'h00, 0, 0};
        vecs[2]  = '{1, 1, 0, 0, 8'h11, 1, 0, 0, 0, 8'h00, 0, 0};
        vecs[3]  = '{1, 1, 0, 0, 8'h22, 2, 0, 0, 0, 8'h00, 0, 0};
        vecs[4]  = '{1, 0, 1, 0, 8'h00, 1, 0, 0, 1, 8'h11, 0, 0};
        vecs[5]  = '{1, 1, 1, 0, 8'h33, 1, 0, 0, 1, 8'h22, 0, 0};
        vecs[6]  = '{1, 0, 1, 0, 8'h00, 0, 1, 0, 1, 8'h33, 0, 0};
        vecs[7]  = '{1, 0, 1, 0, 8'h00, 0, 1, 0, 0, 8'h33, 0, 1};
        vecs[8]  = '{1, 0, 0, 1, 8'h00, 0, 1, 0, 0, 8'h33, 0, 0};
        vecs[9]  = '{1, 1, 1, 0, 8'h44, 1, 0, 0, 0, 8'h33, 0, 1};
        vecs[10] = '{1, 0, 1, 1, 8'h00, 0, 1, 0, 1, 8'h44, 0, 0};
        vecs[11] = '{0, 1, 0, 0, 8'h55, 0, 1, 0, 0, 8'h00, 0, 0};

        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].rn, vecs[i].we, vecs[i].re, vecs[i].clr, vecs[i].d);
            check("vec_count",    32'(bus.count),     32'(vecs[i].cnt));
            check("vec_empty",    32'(bus.empty),     32'(vecs[i].emp));
            check("vec_full",     32'(bus.full),      32'(vecs[i].ful));
            check("vec_rd_valid", 32'(bus.rd_valid),  32'(vecs[i].rv));
            check("vec_rd_data",  32'(bus.rd_data),   32'(vecs[i].rdat));
            check("vec_overflow", 32'(bus.overflow),  32'(vecs[i].ovf));
            check("vec_underflow",32'(bus.underflow), 32'(vecs[i].unf));
        end

        // Reset for two clocks
        apply(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("rst_empty",   32'(bus.empty),        32'd1);
        check("rst_ae",      32'(bus.almost_empty), 32'd1);
        check("rst_count",   32'(bus.count),        32'd0);

        // Fill and drain, with threshold edges
        for (int i = 0; i < 32; i++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0, 8'(i));
            if (i == 26) check("af_below_28", 32'(bus.almost_full), 32'd0);
            if (i == 27) check("af_at_28",    32'(bus.almost_full), 32'd1);
            if (i == 30) check("full_at_31",  32'(bus.full),        32'd0);
        end
        check("full_at_32", 32'(bus.full), 32'd1);
        for (int i = 0; i < 32; i++) begin
            apply(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
            check("drain_valid", 32'(bus.rd_valid), 32'd1);
            check("drain_data",  32'(bus.rd_data),  32'(i));
        end
        check("drain_empty", 32'(bus.empty), 32'd1);

        // Pointer wrap
        for (int i = 0; i < 20; i++) apply(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
        for (int i = 0; i < 20; i++) apply(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) apply(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'hA0 + i));
        for (int i = 0; i < 20; i++) begin
            apply(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
            check("wrap_data", 32'(bus.rd_data), 32'(8'hA0 + i));
        end

        // Full + read + write, then overflow
        for (int i = 0; i < 32; i++) apply(1'b1, 1'b1, 1'b0, 1'b0, 8'(i));
        apply(1'b1, 1'b1, 1'b1, 1'b0, 8'h5A);
        check("fullrw_count", 32'(bus.count),    32'd32);
        check("fullrw_data",  32'(bus.rd_data),  32'h00);
        check("fullrw_ovf",   32'(bus.overflow), 32'd0);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
        check("ovf_set",   32'(bus.overflow), 32'd1);
        check("ovf_count", 32'(bus.count),    32'd32);
        for (int i = 1; i <= 32; i++) begin
            apply(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
            check("fullrw_order", 32'(bus.rd_data), (i == 32) ? 32'h5A : 32'(i));
        end

        // Empty + read + write: no fall-through
        apply(1'b1, 1'b1, 1'b1, 1'b0, 8'h33);
        check("emptyrw_count", 32'(bus.count),     32'd1);
        check("emptyrw_valid", 32'(bus.rd_valid),  32'd0);
        check("emptyrw_unf",   32'(bus.underflow), 32'd1);
        apply(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        check("emptyrw_data",  32'(bus.rd_data),   32'h33);
        apply(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        check("clr_unf", 32'(bus.underflow), 32'd0);
        check("clr_ovf", 32'(bus.overflow),  32'd0);

        // Reset mid-stream
        for (int i = 0; i < 10; i++) apply(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
        check("pre_rst_count", 32'(bus.count), 32'd10);
        apply(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF);
        check("mid_rst_count", 32'(bus.count),    32'd0);
        check("mid_rst_empty", 32'(bus.empty),    32'd1);
        check("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 8'h99);
        apply(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        check("post_rst_data", 32'(bus.rd_data), 32'h99);

        // Randomised traffic in phases biased towards filling, draining, mixing
        for (int ph = 0; ph < 4; ph++) begin
            int p_wr, p_rd;
            p_wr = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
            p_rd = (ph == 0) ? 25 : (ph == 1) ? 75 : 50;
            for (int c = 0; c < 500; c++) begin
                apply(($urandom_range(0, 199) != 0),
                      ($urandom_range(0, 99) < p_wr),
                      ($urandom_range(0, 99) < p_rd),
                      ($urandom_range(0, 15) == 0),
                      8'($urandom));
            end
        end

        idle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
